// File: rtl/rx_frame_ring_buf_if.sv
// On-chip 32-bit bus port of the receive frame ring buffer.
// The master drives address/data/strobes; the slave returns combinational read data.
interface rx_frame_ring_buf_if;
  logic [31:0] bus2ip_addr_i;
  logic [31:0] bus2ip_data_i;
  logic        bus2ip_rd_ce_i;
  logic        bus2ip_wr_ce_i;
  logic [31:0] ip2bus_data_o;

  modport master (
    output bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
    input  ip2bus_data_o
  );

  modport slave (
    input  bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
    output ip2bus_data_o
  );
endinterface

// File: rtl/rx_frame_ring_buf.sv
// Multi-slot XGMII receive frame buffer: captures START..TERMINATE frames into
// circular slots (preamble stripped) and serves them in arrival order over the bus.
module rx_frame_ring_buf #(
  parameter int          SLOTS        = 4,
  parameter int          SLOT_BYTES   = 512,
  parameter logic [31:0] RX_BUF_BADDR = 32'h1000
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [63:0]          xge_rxd_i,
  input  logic [7:0]           xge_rxc_i,
  output logic                 int_rx_o,
  rx_frame_ring_buf_if.slave   bus
);

  localparam int SW = $clog2(SLOTS);
  localparam int OW = $clog2(SLOT_BYTES);
  localparam int CW = SW + 1;
  localparam int BW = OW + 2;

  localparam logic [BW-1:0] C_PRE  = BW'(8);
  localparam logic [BW-1:0] C_MIN  = BW'(9);
  localparam logic [BW-1:0] C_SB   = BW'(SLOT_BYTES);
  localparam logic [BW-1:0] C_BMAX = BW'(SLOT_BYTES + 9);
  localparam logic [CW-1:0] C_FULL = CW'(SLOTS);

  logic [7:0]    r_mem [SLOTS*SLOT_BYTES];
  logic [11:0]   r_len [SLOTS];
  logic          r_open, r_ovf, r_err, r_noslot, r_int;
  logic [BW-1:0] r_cnt;
  logic [SW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_drop_cnt, r_err_cnt;

  logic          w_open, w_ovf, w_err, w_noslot, w_commit;
  logic [BW-1:0] w_cnt, w_off;
  logic [SW-1:0] w_slot;
  logic [11:0]   w_commit_len;
  logic [3:0]    w_err_inc, w_drop_inc;
  logic [7:0]    w_we;
  logic [SW+OW-1:0] w_waddr [8];
  logic          w_in_blk, w_is_data, w_is_stat, w_is_cntr, w_is_clr;
  logic          w_pop, w_clr;
  logic [CW-1:0] w_count_nx;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  // Lanes are walked in order so that abort/commit/START can chain within one word.
  always_comb begin
    w_open       = r_open;
    w_cnt        = r_cnt;
    w_ovf        = r_ovf;
    w_err        = r_err;
    w_noslot     = r_noslot;
    w_slot       = r_wr_ptr;
    w_commit     = 1'b0;
    w_commit_len = 12'h0;
    w_err_inc    = 4'd0;
    w_drop_inc   = 4'd0;
    w_we         = 8'h0;
    w_off        = '0;
    for (int li = 0; li < 8; li++) begin
      w_waddr[li] = '0;
      if (xge_rxc_i[li]) begin
        if (xge_rxd_i[8*li +: 8] == 8'hFB) begin
          if (w_open) w_err_inc = w_err_inc + 4'd1;
          w_open   = 1'b1;
          w_cnt    = BW'(1);
          w_ovf    = 1'b0;
          w_err    = 1'b0;
          w_noslot = (r_count + CW'(w_commit)) == C_FULL;
        end else if (xge_rxd_i[8*li +: 8] == 8'hFD && w_open) begin
          w_open = 1'b0;
          if (w_noslot) begin
            w_drop_inc = w_drop_inc + 4'd1;
          end else if (w_ovf || w_err || w_cnt < C_MIN) begin
            w_err_inc = w_err_inc + 4'd1;
          end else begin
            w_commit     = 1'b1;
            w_commit_len = 12'(w_cnt - C_PRE);
            w_slot       = r_wr_ptr + SW'(1);
          end
        end else if (xge_rxd_i[8*li +: 8] == 8'hFE && w_open) begin
          w_err = 1'b1;
        end
      end else if (w_open) begin
        if (w_cnt >= C_PRE) begin
          w_off = w_cnt - C_PRE;
          if (w_off < C_SB) begin
            if (!w_noslot) begin
              w_we[li]    = 1'b1;
              w_waddr[li] = {w_slot, w_off[OW-1:0]};
            end
          end else begin
            w_ovf = 1'b1;
          end
        end
        if (w_cnt < C_BMAX) w_cnt = w_cnt + BW'(1);
      end
    end
  end

  assign w_in_blk  = bus.bus2ip_addr_i[31:OW+1] == RX_BUF_BADDR[31:OW+1];
  assign w_is_data = w_in_blk && !bus.bus2ip_addr_i[OW];
  assign w_is_stat = w_in_blk && bus.bus2ip_addr_i[OW] && bus.bus2ip_addr_i[OW-1:0] == OW'(0);
  assign w_is_cntr = w_in_blk && bus.bus2ip_addr_i[OW] && bus.bus2ip_addr_i[OW-1:0] == OW'(4);
  assign w_is_clr  = w_in_blk && bus.bus2ip_addr_i[OW] && bus.bus2ip_addr_i[OW-1:0] == OW'(8);
  assign w_pop     = bus.bus2ip_wr_ce_i && w_is_cntr && (r_count != '0);
  assign w_clr     = bus.bus2ip_wr_ce_i && w_is_clr;
  assign w_count_nx = r_count + CW'(w_commit) - CW'(w_pop);
  assign w_unused  = ^bus.bus2ip_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_byte
      assign w_rd_word[8*gi +: 8] = r_mem[{r_rd_ptr, bus.bus2ip_addr_i[OW-1:2], 2'(gi)}];
    end
  endgenerate

  always_comb begin
    bus.ip2bus_data_o = 32'h0;
    if (bus.bus2ip_rd_ce_i) begin
      if (w_is_data)
        bus.ip2bus_data_o = w_rd_word;
      else if (w_is_stat)
        bus.ip2bus_data_o = {8'(r_count), 12'h0, (r_count != '0) ? r_len[r_rd_ptr] : 12'h0};
      else if (w_is_cntr)
        bus.ip2bus_data_o = {r_drop_cnt, r_err_cnt};
    end
  end

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'h0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r_open     <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_noslot   <= 1'b0;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= 16'h0;
      r_err_cnt  <= 16'h0;
      r_int      <= 1'b0;
    end else begin
      r_open   <= w_open;
      r_ovf    <= w_ovf;
      r_err    <= w_err;
      r_noslot <= w_noslot;
      r_cnt    <= w_cnt;
      if (w_commit) r_wr_ptr <= r_wr_ptr + SW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + SW'(1);
      r_count <= w_count_nx;
      r_int   <= w_count_nx != '0;
      if (w_clr) begin
        r_drop_cnt <= 16'h0;
        r_err_cnt  <= 16'h0;
      end else begin
        r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
        r_err_cnt  <= sat_add(r_err_cnt, w_err_inc);
      end
    end
  end

  // Payload and length storage carry no reset; only committed slots are ever read.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      for (int li = 0; li < 8; li++) begin
        if (w_we[li]) r_mem[w_waddr[li]] <= xge_rxd_i[8*li +: 8];
      end
      if (w_commit) r_len[r_wr_ptr] <= w_commit_len;
    end
  end

  assign int_rx_o = r_int;

endmodule

// File: doc/rx_frame_ring_buf.md
# rx_frame_ring_buf

Multi-slot receive frame buffer on the 10G XGMII receive path: captures every frame delimited by START/TERMINATE into one of SLOTS circular slots, strips the 8-byte START/preamble/SFD, records its length and lets software read frames in arrival order over the 32-bit on-chip bus. It generalises the single-frame PTP receive buffer with parametrised slot count and depth, a pop handshake, error/overflow dropping, drop counting and a level interrupt. It sits beside the PTP parser, tapping the same xge_rxd/xge_rxc stream.

## Interface
- SLOTS, 4: number of frame slots; power of two, 2..16.
- SLOT_BYTES, 512: bytes per slot; power of two, 64..2048; maximum stored frame length.
- RX_BUF_BADDR, 32'h1000: bus base address; aligned to SLOT_BYTES*2.
- rx_clk  in  1  single clock for receive and bus logic (bus2ip_* are synchronous to rx_clk).
- rx_rst  in  1  synchronous, active-high reset.
- xge_rxd_i  in  64  XGMII data, lane i = bits [8i+7:8i].
- xge_rxc_i  in  8  XGMII control, bit i for lane i.
- int_rx_o  out  1  level interrupt: high while at least one committed frame is unread.
- bus2ip_addr_i  in  32  byte address.
- bus2ip_data_i  in  32  write data.
- bus2ip_rd_ce_i  in  1  read strobe, active high.
- bus2ip_wr_ce_i  in  1  write strobe, active high, one cycle per access.
- ip2bus_data_o  out  32  read data, combinational from address and rd_ce.

## Operation
- Lanes are processed 0..7 in order within a cycle; several events may occur in one cycle.
- Lane control 0xFB (START): opens a frame. If a frame is already open it is aborted (err_cnt+1). Byte counter = 1 (the START byte counts as preamble byte 0).
- Lane data (rxc=0) while open: byte counter increments; bytes 0..7 (START + preamble + SFD) are discarded; byte n>=8 is stored at slot offset n-8. Bytes beyond SLOT_BYTES set the overflow flag and are not stored.
- Lane control 0xFD (TERMINATE) while open: length = count-8 (FCS included). Commit only if length>=1, no overflow, no error, and the slot is valid; otherwise discard and err_cnt+1 (overflow or error) or drop_cnt+1 (no slot). Frame closes.
- Lane control 0xFE (ERROR) while open: sets the error flag.
- Other control characters (idle 0x07 etc.) are ignored.
- Slot allocation happens at START: if count==SLOTS the frame is marked no-slot and its bytes are not stored.
- Commit: len[wr_ptr]<=length; wr_ptr<=wr_ptr+1 mod SLOTS; count+1.
- Bus map (rd_ce=1):
  - RX_BUF_BADDR + 4k, k<SLOT_BYTES/4: word k of the head slot (rd_ptr), little-endian {b[4k+3],b[4k+2],b[4k+1],b[4k]}.
  - +SLOT_BYTES: {count[7:0], 12'b0, len[rd_ptr][11:0]}; len field = 0 when count==0.
  - +SLOT_BYTES+4: {drop_cnt[15:0], err_cnt[15:0]}.
  - any other address or rd_ce=0: 32'h0. Bytes past len are unspecified.
- Bus write: a write of any data to +SLOT_BYTES+4 with count>0 pops the head (rd_ptr+1, count-1). Popping while empty has no effect. A write to +SLOT_BYTES+8 clears drop_cnt and err_cnt. Other writes are ignored.
- drop_cnt and err_cnt are 16-bit and saturate at 16'hFFFF.

## Timing
- Reset: count, rd_ptr, wr_ptr, counters and the open/overflow/error flags clear to 0; int_rx_o=0; no frame open. Slot contents are not reset. Reset mid-frame discards that frame without counting it.
- Commit on the TERMINATE cycle is visible in count/len on the next rx_clk edge; int_rx_o rises on that edge (1-cycle latency from the TERMINATE cycle).
- Pop takes effect on the edge ending the write cycle. int_rx_o falls on that edge if count becomes 0.
- Commit and pop in the same cycle: count unchanged, both pointers advance.
- A frame that STARTs while the buffer is full is dropped even if a pop happens during reception.
- Back-to-back frames (TERMINATE and START in the same 64-bit word) are both handled.
- A read never changes state.

## Test plan
- Single 64-byte frame: START in lane 0, 7 preamble/SFD bytes, bytes 0x00..0x3F, TERMINATE -> one cycle later int_rx_o=1 and status = 0x01000040; word 0 = 0x03020100; after the pop, int_rx_o=0 and status = 0.
- START in lane 4, 61-byte frame -> length 61 and byte alignment correct; word 15 low byte = byte 60.
- Five 100-byte frames with no pops, SLOTS=4 -> count=4, drop_cnt=1; pops return frames 1-4 in order and the payload tags match.
- 600-byte frame -> not committed, err_cnt=1. Frame containing an ERROR char -> not committed, err_cnt=2. A following good frame is committed normally.
- Pop write in the same cycle as a TERMINATE commit with count=2 -> count stays 2 and the head advances. Reset asserted mid-frame -> everything 0 and the next frame is received correctly.
- Write to +SLOT_BYTES+8 clears both counters. Counter saturation is checked by forcing 65536+ drops: drop_cnt = 0xFFFF.
